// File: rtl/exe_stage_if.sv
// ID/EX -> EX bundle plus EX/MEM results and IF branch feedback for exe_stage.
// Forwarding inputs are present only when FORWARDING_EN is defined.
interface exe_stage_if #(
    parameter int WIDTH = 32
);
    logic             wbEnIn;
    logic             memrEnIn;
    logic             memwEnIn;
    logic             sIn;
    logic             bIn;
    logic [3:0]       exeCmdIn;
    logic [WIDTH-1:0] pcIn;
    logic [WIDTH-1:0] rnValIn;
    logic [WIDTH-1:0] rmValIn;
    logic             immIn;
    logic [11:0]      shOprIn;
    logic [23:0]      signedImm24In;
    logic [3:0]       destIn;
`ifdef FORWARDING_EN
    logic [1:0]       selSrc1;
    logic [1:0]       selSrc2;
    logic [WIDTH-1:0] memFwdVal;
    logic [WIDTH-1:0] wbFwdVal;
`endif
    logic             branchTaken;
    logic [WIDTH-1:0] branchAddr;
    logic [3:0]       status;
    logic             wbEn;
    logic             memrEn;
    logic             memwEn;
    logic [WIDTH-1:0] aluRes;
    logic [WIDTH-1:0] storeVal;
    logic [3:0]       dest;

    modport master (
        output wbEnIn, memrEnIn, memwEnIn, sIn, bIn, exeCmdIn, pcIn,
               rnValIn, rmValIn, immIn, shOprIn, signedImm24In, destIn,
`ifdef FORWARDING_EN
               selSrc1, selSrc2, memFwdVal, wbFwdVal,
`endif
        input  branchTaken, branchAddr, status, wbEn, memrEn, memwEn,
               aluRes, storeVal, dest
    );

    modport slave (
        input  wbEnIn, memrEnIn, memwEnIn, sIn, bIn, exeCmdIn, pcIn,
               rnValIn, rmValIn, immIn, shOprIn, signedImm24In, destIn,
`ifdef FORWARDING_EN
               selSrc1, selSrc2, memFwdVal, wbFwdVal,
`endif
        output branchTaken, branchAddr, status, wbEn, memrEn, memwEn,
               aluRes, storeVal, dest
    );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: operand-2 generation, ALU with NZCV register, branch target, EX/MEM register.
// Optional operand forwarding muxes are built when FORWARDING_EN is defined.
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    exe_stage_if.slave    bus
);
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    function automatic logic [WIDTH-1:0] ror_f(input logic [WIDTH-1:0] x, input logic [4:0] r);
        logic [2*WIDTH-1:0] t;
        t = {x, x} >> r;
        return t[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] rn_s;
    logic [WIDTH-1:0] rm_s;
    logic [WIDTH-1:0] val2_s;
    logic [WIDTH-1:0] res_s;
    logic [WIDTH:0]   sum_s;
    logic             c_s;
    logic             v_s;
    logic             cmd_ok_s;
    logic [3:0]       status_d;
    logic [3:0]       status_q;
    logic             wb_en_q;
    logic             memr_en_q;
    logic             memw_en_q;
    logic [WIDTH-1:0] alu_res_q;
    logic [WIDTH-1:0] store_val_q;
    logic [3:0]       dest_q;
    logic [4:0]       sh_amt_s;

`ifdef FORWARDING_EN
    // Source selection between register file value and forwarded results.
    always_comb begin
        case (bus.selSrc1)
            2'b01:   rn_s = bus.memFwdVal;
            2'b10:   rn_s = bus.wbFwdVal;
            default: rn_s = bus.rnValIn;
        endcase
        case (bus.selSrc2)
            2'b01:   rm_s = bus.memFwdVal;
            2'b10:   rm_s = bus.wbFwdVal;
            default: rm_s = bus.rmValIn;
        endcase
    end
`else
    assign rn_s = bus.rnValIn;
    assign rm_s = bus.rmValIn;
`endif

    assign sh_amt_s = bus.shOprIn[11:7];

    // Operand 2: a zero shift amount leaves Rm unchanged for every shift type.
    always_comb begin
        if (bus.immIn) begin
            val2_s = ror_f({{(WIDTH-8){1'b0}}, bus.shOprIn[7:0]}, {bus.shOprIn[11:8], 1'b0});
        end else if (bus.memrEnIn || bus.memwEnIn) begin
            val2_s = {{(WIDTH-12){1'b0}}, bus.shOprIn};
        end else begin
            case (bus.shOprIn[6:5])
                2'b00:   val2_s = rm_s << sh_amt_s;
                2'b01:   val2_s = rm_s >> sh_amt_s;
                2'b10:   val2_s = $signed(rm_s) >>> sh_amt_s;
                2'b11:   val2_s = ror_f(rm_s, sh_amt_s);
                default: val2_s = rm_s;
            endcase
        end
    end

    // ALU; subtraction is rn + ~val2 + carry_in so the carry out is ARM's NOT-borrow.
    always_comb begin
        res_s    = {WIDTH{1'b0}};
        sum_s    = {(WIDTH+1){1'b0}};
        c_s      = status_q[1];
        v_s      = status_q[0];
        cmd_ok_s = 1'b1;
        case (bus.exeCmdIn)
            CMD_MOV: res_s = val2_s;
            CMD_MVN: res_s = ~val2_s;
            CMD_ADD, CMD_ADC: begin
                sum_s = {1'b0, rn_s} + {1'b0, val2_s}
                      + {{WIDTH{1'b0}}, (bus.exeCmdIn == CMD_ADC) ? status_q[1] : 1'b0};
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = (rn_s[WIDTH-1] == val2_s[WIDTH-1]) && (res_s[WIDTH-1] != rn_s[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum_s = {1'b0, rn_s} + {1'b0, ~val2_s}
                      + {{WIDTH{1'b0}}, (bus.exeCmdIn == CMD_SBC) ? status_q[1] : 1'b1};
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = (rn_s[WIDTH-1] != val2_s[WIDTH-1]) && (res_s[WIDTH-1] != rn_s[WIDTH-1]);
            end
            CMD_AND: res_s = rn_s & val2_s;
            CMD_ORR: res_s = rn_s | val2_s;
            CMD_EOR: res_s = rn_s ^ val2_s;
            default: cmd_ok_s = 1'b0;
        endcase
    end

    // Unknown commands (including bubbles) never touch the flags.
    always_comb begin
        if (bus.sIn && cmd_ok_s) begin
            status_d = {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), c_s, v_s};
        end else begin
            status_d = status_q;
        end
    end

    // Status register and EX/MEM pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q    <= 4'b0000;
            wb_en_q     <= 1'b0;
            memr_en_q   <= 1'b0;
            memw_en_q   <= 1'b0;
            alu_res_q   <= {WIDTH{1'b0}};
            store_val_q <= {WIDTH{1'b0}};
            dest_q      <= 4'b0000;
        end else begin
            status_q    <= status_d;
            wb_en_q     <= bus.wbEnIn;
            memr_en_q   <= bus.memrEnIn;
            memw_en_q   <= bus.memwEnIn;
            alu_res_q   <= res_s;
            store_val_q <= rm_s;
            dest_q      <= bus.destIn;
        end
    end

    assign bus.branchTaken = bus.bIn;
    assign bus.branchAddr  = bus.pcIn + {{(WIDTH-26){bus.signedImm24In[23]}}, bus.signedImm24In, 2'b00};
    assign bus.status      = status_q;
    assign bus.wbEn        = wb_en_q;
    assign bus.memrEn      = memr_en_q;
    assign bus.memwEn      = memw_en_q;
    assign bus.aluRes      = alu_res_q;
    assign bus.storeVal    = store_val_q;
    assign bus.dest        = dest_q;
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with hand-computed expectations; forwarding steps need FORWARDING_EN.
module tb_exe_stage;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    exe_stage_if #(.WIDTH(32)) bus ();

    exe_stage #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.wbEnIn = 1'b0; bus.memrEnIn = 1'b0; bus.memwEnIn = 1'b0;
        bus.sIn = 1'b0; bus.bIn = 1'b0; bus.exeCmdIn = 4'h0;
        bus.pcIn = 32'h0; bus.rnValIn = 32'h0; bus.rmValIn = 32'h0;
        bus.immIn = 1'b0; bus.shOprIn = 12'h000; bus.signedImm24In = 24'h000000;
        bus.destIn = 4'h0;
`ifdef FORWARDING_EN
        bus.selSrc1 = 2'b00; bus.selSrc2 = 2'b00;
        bus.memFwdVal = 32'h0; bus.wbFwdVal = 32'h0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clr();
        #12;
        chk("rst_alu", bus.aluRes, 32'h0);
        chk("rst_status", {28'h0, bus.status}, 32'h0);
        chk("rst_store", bus.storeVal, 32'h0);
        chk("rst_ctl", {25'h0, bus.wbEn, bus.memrEn, bus.memwEn, bus.dest}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ADD overflow into sign bit
        clr(); bus.exeCmdIn = 4'b0010; bus.sIn = 1'b1; bus.immIn = 1'b1; bus.shOprIn = 12'h001;
        bus.rnValIn = 32'h7FFF_FFFF; bus.wbEnIn = 1'b1; bus.destIn = 4'h3;
        step();
        chk("add_res", bus.aluRes, 32'h8000_0000);
        chk("add_status", {28'h0, bus.status}, 32'h9);
        chk("add_wb_dest", {27'h0, bus.wbEn, bus.dest}, 32'h13);

        // CMP equal
        clr(); bus.exeCmdIn = 4'b0100; bus.sIn = 1'b1; bus.rnValIn = 32'h5; bus.rmValIn = 32'h5;
        step();
        chk("sub_res", bus.aluRes, 32'h0);
        chk("sub_status", {28'h0, bus.status}, 32'h6);

        // AND keeps C and V
        clr(); bus.exeCmdIn = 4'b0110; bus.sIn = 1'b1; bus.rnValIn = 32'hC; bus.rmValIn = 32'h6;
        step();
        chk("and_res", bus.aluRes, 32'h4);
        chk("and_status", {28'h0, bus.status}, 32'h2);

        // ADC with C=1: 1+2+1
        clr(); bus.exeCmdIn = 4'b0011; bus.sIn = 1'b1; bus.rnValIn = 32'h1; bus.rmValIn = 32'h2;
        step();
        chk("adc_res", bus.aluRes, 32'h4);
        chk("adc_status", {28'h0, bus.status}, 32'h0);

        // SBC with C=0: 5-2-1
        clr(); bus.exeCmdIn = 4'b0101; bus.sIn = 1'b1; bus.rnValIn = 32'h5; bus.rmValIn = 32'h2;
        step();
        chk("sbc_res", bus.aluRes, 32'h2);
        chk("sbc_status", {28'h0, bus.status}, 32'h2);

        // bubble
        clr();
        step();
        chk("bubble_res", bus.aluRes, 32'h0);
        chk("bubble_status", {28'h0, bus.status}, 32'h2);

        // unknown command with sIn=1 leaves flags alone
        clr(); bus.exeCmdIn = 4'b1111; bus.sIn = 1'b1; bus.rnValIn = 32'h1; bus.rmValIn = 32'h1;
        step();
        chk("badcmd_res", bus.aluRes, 32'h0);
        chk("badcmd_status", {28'h0, bus.status}, 32'h2);

        // MOV rotated immediate 0xFF ror 8
        clr(); bus.exeCmdIn = 4'b0001; bus.sIn = 1'b1; bus.immIn = 1'b1; bus.shOprIn = 12'h4FF;
        step();
        chk("mov_imm_res", bus.aluRes, 32'hFF00_0000);
        chk("mov_imm_status", {28'h0, bus.status}, 32'hA);

        // MOV ASR #4
        clr(); bus.exeCmdIn = 4'b0001; bus.rmValIn = 32'h8000_0000; bus.shOprIn = 12'h240;
        step();
        chk("mov_asr_res", bus.aluRes, 32'hF800_0000);
        chk("mov_asr_status", {28'h0, bus.status}, 32'hA);

        // MVN LSR #4
        clr(); bus.exeCmdIn = 4'b1001; bus.rmValIn = 32'hF0; bus.shOprIn = 12'h220;
        step();
        chk("mvn_lsr_res", bus.aluRes, 32'hFFFF_FFF0);

        // ORR ROR #8
        clr(); bus.exeCmdIn = 4'b0111; bus.rnValIn = 32'h1; bus.rmValIn = 32'hF0; bus.shOprIn = 12'h460;
        step();
        chk("orr_ror_res", bus.aluRes, 32'hF000_0001);

        // EOR LSL #4
        clr(); bus.exeCmdIn = 4'b1000; bus.sIn = 1'b1; bus.rnValIn = 32'hFF; bus.rmValIn = 32'h0F;
        bus.shOprIn = 12'h200;
        step();
        chk("eor_lsl_res", bus.aluRes, 32'h0F);
        chk("eor_status", {28'h0, bus.status}, 32'h2);

        // branch: combinational before the edge
        @(negedge clk);
        clr(); bus.bIn = 1'b1; bus.pcIn = 32'h100; bus.signedImm24In = 24'hFFFFFE;
        #1;
        chk("br_taken", {31'h0, bus.branchTaken}, 32'h1);
        chk("br_addr", bus.branchAddr, 32'h0F8);
        step();
        chk("br_ctl", {29'h0, bus.wbEn, bus.memrEn, bus.memwEn}, 32'h0);

        // LDR with full 12-bit offset
        clr(); bus.exeCmdIn = 4'b0010; bus.memrEnIn = 1'b1; bus.wbEnIn = 1'b1; bus.rnValIn = 32'h100;
        bus.shOprIn = 12'hFFF; bus.destIn = 4'h7;
        step();
        chk("ldr_addr", bus.aluRes, 32'h10FF);
        chk("ldr_ctl", {25'h0, bus.wbEn, bus.memrEn, bus.memwEn, bus.dest}, 32'h67);

        // STR
        clr(); bus.exeCmdIn = 4'b0010; bus.memwEnIn = 1'b1; bus.rnValIn = 32'h400;
        bus.shOprIn = 12'h004; bus.rmValIn = 32'hDEAD;
        step();
        chk("str_addr", bus.aluRes, 32'h404);
        chk("str_val", bus.storeVal, 32'hDEAD);
        chk("str_memw", {31'h0, bus.memwEn}, 32'h1);

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_alu", bus.aluRes, 32'h0);
        chk("arst_store", bus.storeVal, 32'h0);
        chk("arst_ctl", {25'h0, bus.wbEn, bus.memrEn, bus.memwEn, bus.dest}, 32'h0);
        chk("arst_status", {28'h0, bus.status}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef FORWARDING_EN
        clr(); bus.exeCmdIn = 4'b0010; bus.immIn = 1'b1; bus.shOprIn = 12'h002;
        bus.rnValIn = 32'h3; bus.selSrc1 = 2'b01; bus.memFwdVal = 32'd10;
        step();
        chk("fwd_rn_mem", bus.aluRes, 32'd12);

        clr(); bus.exeCmdIn = 4'b0010; bus.memwEnIn = 1'b1; bus.rnValIn = 32'h400;
        bus.shOprIn = 12'h008; bus.rmValIn = 32'hDEAD; bus.selSrc2 = 2'b10; bus.wbFwdVal = 32'h55;
        step();
        chk("fwd_store_wb", bus.storeVal, 32'h55);
        chk("fwd_store_addr", bus.aluRes, 32'h408);

        clr(); bus.exeCmdIn = 4'b0001; bus.rmValIn = 32'h1; bus.selSrc2 = 2'b11; bus.wbFwdVal = 32'h77;
        step();
        chk("fwd_sel11", bus.aluRes, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage 32-bit ARM pipeline; sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Generates the second operand (val2): rotated immediate, 12-bit memory offset, or shifted Rm.
- Performs the ALU operation and maintains the NZCV status register.
- Produces the branch target for IF and drives the registered EX/MEM pipeline outputs.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wbEnIn, memrEnIn, memwEnIn  in  1 each  control from ID/EX
- sIn  in  1  update status when high
- bIn  in  1  branch instruction
- exeCmdIn  in  4  ALU command
- pcIn  in  32  PC+4 of this instruction
- rnValIn, rmValIn  in  32 each  register operands
- immIn  in  1  immediate operand form
- shOprIn  in  12  shifter operand field
- signedImm24In  in  24  branch offset
- destIn  in  4  destination register
- branchTaken  out  1  combinational to IF; equals bIn
- branchAddr  out  32  combinational to IF
- status  out  4  registered {N,Z,C,V}; to ID condition check
- wbEn, memrEn, memwEn  out  1 each  registered EX/MEM control
- aluRes  out  32  registered ALU result / memory address
- storeVal  out  32  registered Rm value for STR
- dest  out  4  registered destination

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On rst, every registered output (status, wbEn, memrEn, memwEn, aluRes, storeVal, dest) goes to 0 immediately, regardless of clk.
- Latency: EX/MEM outputs update on the posedge after their inputs are presented, i.e. one cycle.
- branchTaken and branchAddr are combinational, zero latency.
- branchAddr = pcIn + (signextend(signedImm24In) << 2), 32-bit, wraps modulo 2^32.
- val2 selection:
  - immIn=1: zero-extend shOprIn[7:0] to 32 bits, then rotate right by 2*shOprIn[11:8]. Rotate 0 passes the value through.
  - else if memrEnIn or memwEnIn: zero-extend shOprIn[11:0].
  - else shift Rm by shOprIn[11:7] using type shOprIn[6:5]:
    - 00 LSL, 01 LSR, 10 ASR, 11 ROR.
    - Shift amount 0 passes Rm through unchanged for all types.
- exeCmd encoding (res = result):
  - 0001 MOV: res = val2
  - 1001 MVN: res = ~val2
  - 0010 ADD: res = rn + val2
  - 0011 ADC: res = rn + val2 + C
  - 0100 SUB/CMP: res = rn - val2
  - 0101 SBC: res = rn - val2 - !C
  - 0110 AND/TST: res = rn & val2
  - 0111 ORR: res = rn | val2
  - 1000 EOR: res = rn ^ val2
  - Any other code gives res = 0 and no flag change.
  - C means the current registered status C.
- Flag computation:
  - N = res[31]; Z = (res == 0).
  - Add ops: C = carry out of bit 31; V = signed overflow.
  - Sub ops: C = NOT borrow (ARM convention); V = signed overflow.
  - MOV/MVN/logic ops: C and V keep their previous values.
- Status register: loads the new NZCV on posedge when sIn=1; otherwise it holds.
- LDR/STR arrive as exeCmd 0010 (address = rn + offset) with sIn=0.
- Branch inputs arrive with wbEn=memrEn=memwEn=0 from ID. The stage does not alter those controls; the EX/MEM register captures them unchanged.
- Bubbles: all-zero inputs, as from a flushed ID/EX, give exeCmd 0000, which yields aluRes 0, no status change and no side effects.
- storeVal <= rmValIn, or the forwarded value when forwarding is enabled.

Optional Feature:
- Macro: FORWARDING_EN.
- Enabled: adds inputs selSrc1 [1:0], selSrc2 [1:0], memFwdVal [32], wbFwdVal [32].
  - Selector codes: 00 = register value, 01 = memFwdVal, 10 = wbFwdVal, 11 = register value.
  - selSrc1 muxes Rn before the ALU.
  - selSrc2 muxes Rm before the shifter and before storeVal.
- Disabled: these ports do not exist; rnValIn and rmValIn are used directly.

Test Plan:
- Reset then ADD: rn=0x7FFFFFFF, imm val2=1, sIn=1 -> next cycle aluRes=0x80000000, status=1001 (N=1, V=1).
- SUB/CMP: rn=5, Rm=5, LSL 0, sIn=1 -> aluRes=0, status=0110 (Z=1, C=1). Follow with AND, sIn=1, giving res 0x00000004 -> status=0010 (N=0, Z=0; C=1, V=0 retained).
- Immediate rotate: imm8=0xFF, rotate=4 -> val2=0xFF000000. MOV gives aluRes=0xFF000000. Also ASR #4 of 0x80000000 -> 0xF8000000.
- Branch: pcIn=0x100, signedImm24In=0xFFFFFE -> branchTaken=1, branchAddr=0x0F8 in the same cycle; EX/MEM wbEn=0.
- STR: memwEnIn=1, rn=0x400, offset 0x004, Rm=0xDEAD -> aluRes=0x404, storeVal=0xDEAD, memwEn=1. Assert rst mid-cycle -> all outputs 0 immediately, before the next clk edge.
- FORWARDING_EN: selSrc1=01, memFwdVal=10, rn=3, ADD, imm val2=2 -> aluRes=12. With selSrc2=10, wbFwdVal=0x55 on STR -> storeVal=0x55.
